stage_sequencer: RTL and testbench
==================================

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 6, number of pipeline-less execution stages (min 2, max 16).
REQ-002 Parameter TIMEOUT_CYCLES, default 255, max wait cycles per stage before fault; 0 disables the timeout.
REQ-003 Parameter INSTRET_W, default 32, width of retired-instruction counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 enable_mask  input  NUM_STAGES  per-stage enable for the current instruction; bit 0 treated as 1 regardless of input.
REQ-007 stage_done  input  1  current stage has completed its work this cycle.
REQ-008 ext_fault  input  1  fault reported by any unit; sampled every RUN cycle.
REQ-009 stage_active  output  NUM_STAGES  one-hot active stage; all-zero outside RUN.
REQ-010 stage_first  output  1  high on the first cycle of each stage activation.
REQ-011 retire  output  1  one-cycle pulse when an instruction completes its last enabled stage.
REQ-012 instret  output  INSTRET_W  count of retired instructions.
REQ-013 timeout_fault  output  1  sticky, set when a stage exceeds TIMEOUT_CYCLES.
REQ-014 halted  output  1  high while in HALT.

Function
REQ-015 States: IDLE, RUN, HALT; IDLE only entered by reset.
REQ-016 IDLE -> RUN on the first rising edge after reset deasserts; stage 0 becomes active with stage_first=1.
REQ-017 In RUN, stage_active holds its value while stage_done=0.
REQ-018 On stage_done=1, next stage = lowest index j > current with enable_mask[j]=1, sampled in that same cycle.
REQ-019 If no such j exists, next stage = 0, retire pulses in that cycle, instret increments by 1.
REQ-020 instret wraps modulo 2^INSTRET_W without flagging.
REQ-021 stage_first=1 in the cycle after any stage transition, including 0 -> 0 when only stage 0 is enabled.
REQ-022 Wait counter clears on every transition and increments each RUN cycle with stage_done=0, saturating at TIMEOUT_CYCLES.
REQ-023 When the wait counter equals TIMEOUT_CYCLES (non-zero) and stage_done=0, next state = HALT and timeout_fault=1.
REQ-024 stage_done=1 in the same cycle the counter reaches the limit: the transition wins and there is no fault.
REQ-025 ext_fault=1 in RUN: next state = HALT; this takes priority over stage_done, no retire, instret unchanged.
REQ-026 HALT: stage_active=0, stage_first=0, retire=0, halted=1; exit only via reset.
REQ-027 Latency: stage_active reflects a transition one cycle after the stage_done/ext_fault sample.

Reset
REQ-028 While reset=0: state IDLE, stage_active=0, stage_first=0, retire=0, instret=0, timeout_fault=0, halted=0, wait counter=0.
REQ-029 Reset asserted mid-instruction aborts the instruction immediately (asynchronously) with no retire pulse.

Structure
REQ-030 Shared package core_pkg holds: state enum (IDLE/RUN/HALT), default NUM_STAGES, and stage index constants STAGE_FETCH=0, STAGE_DECODE=1, STAGE_READ=2, STAGE_EXECUTE=3, STAGE_MEMORY=4, STAGE_WRITE_BACK=5.
REQ-031 Next-stage selection is a combinational sub-module next_stage_select (current one-hot + mask -> next one-hot + wrap flag).
REQ-032 Counter widths are derived from the parameters with $clog2; there are no hard-coded widths.

Verification
REQ-033 Mask=6'b111111, stage_done always 1 -> stage_active walks 1,2,4,...,32,1; retire every 6th cycle; instret=3 after 18 RUN cycles.
REQ-034 Mask=6'b101011, done always 1 -> sequence stages 0,1,3,5,0; retire pulse on each stage-5 exit.
REQ-035 TIMEOUT_CYCLES=4, done held 0 in stage 2 -> HALT after 5 cycles in stage; timeout_fault=1, stage_active=0.
REQ-036 ext_fault and stage_done both 1 in stage 5 -> HALT, retire=0, instret unchanged.
REQ-037 INSTRET_W=3, run 9 instructions -> instret reads 1 after wrap.
REQ-038 reset driven low mid-stage 3 (asynchronously, between edges) -> outputs zero immediately; after release, stage 0 is active on the first edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the stage sequencer: state encoding,
// default stage count and the symbolic indices of the execution stages.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } seq_state_t;

    localparam int DEFAULT_NUM_STAGES = 6;

    localparam int STAGE_FETCH      = 0;
    localparam int STAGE_DECODE     = 1;
    localparam int STAGE_READ       = 2;
    localparam int STAGE_EXECUTE    = 3;
    localparam int STAGE_MEMORY     = 4;
    localparam int STAGE_WRITE_BACK = 5;

endpackage

// File: rtl/next_stage_select.sv
// Picks the lowest enabled stage above the current one-hot stage; when none
// is left the instruction is finished and selection wraps back to fetch.
module next_stage_select
    import core_pkg::*;
#(
    parameter int NUM_STAGES = DEFAULT_NUM_STAGES
) (
    input  logic [NUM_STAGES-1:0] cur_onehot,
    input  logic [NUM_STAGES-1:0] enable_mask,
    output logic [NUM_STAGES-1:0] next_onehot,
    output logic                  wrap
);

    logic past_cur;
    logic found;

    always_comb begin
        next_onehot = '0;
        past_cur    = 1'b0;
        found       = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (past_cur && enable_mask[i] && !found) begin
                next_onehot[i] = 1'b1;
                found          = 1'b1;
            end
            if (cur_onehot[i]) begin
                past_cur = 1'b1;
            end
        end
        if (!found) begin
            next_onehot[STAGE_FETCH] = 1'b1;
        end
        wrap = !found;
    end

endmodule

// File: rtl/stage_sequencer.sv
// Walks an instruction through its enabled execution stages, counts retired
// instructions and halts on an external fault or a per-stage wait timeout.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | held by reset; leaves on the first edge after release
//   RUN   | one stage active, advancing on stage_done
//   HALT  | stopped by ext_fault or timeout; only reset leaves it
module stage_sequencer
    import core_pkg::*;
#(
    parameter int NUM_STAGES     = DEFAULT_NUM_STAGES,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int INSTRET_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_STAGES-1:0] enable_mask,
    input  logic                  stage_done,
    input  logic                  ext_fault,
    output logic [NUM_STAGES-1:0] stage_active,
    output logic                  stage_first,
    output logic                  retire,
    output logic [INSTRET_W-1:0]  instret,
    output logic                  timeout_fault,
    output logic                  halted
);

    localparam int WAIT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WAIT_W-1:0]     WAIT_LIMIT   = WAIT_W'(TIMEOUT_CYCLES);
    localparam logic [NUM_STAGES-1:0] FETCH_ONEHOT = NUM_STAGES'(1) << STAGE_FETCH;

    seq_state_t            state, state_nxt;
    logic [NUM_STAGES-1:0] cur_stage, cur_stage_nxt;
    logic                  first_q, first_nxt;
    logic [WAIT_W-1:0]     wait_cnt, wait_cnt_nxt;
    logic [INSTRET_W-1:0]  instret_q, instret_nxt;
    logic                  tfault_q, tfault_nxt;

    logic [NUM_STAGES-1:0] mask_eff;
    logic [NUM_STAGES-1:0] sel_next;
    logic                  sel_wrap;
    logic                  advance;
    logic                  at_limit;
    logic                  retire_now;

    // Fetch always runs, whatever the mask says.
    assign mask_eff   = enable_mask | FETCH_ONEHOT;
    assign advance    = (state == RUN) && !ext_fault && stage_done;
    assign retire_now = advance && sel_wrap;
    assign at_limit   = (TIMEOUT_CYCLES != 0) && (wait_cnt == WAIT_LIMIT);

    next_stage_select #(
        .NUM_STAGES (NUM_STAGES)
    ) u_next_stage_select (
        .cur_onehot  (cur_stage),
        .enable_mask (mask_eff),
        .next_onehot (sel_next),
        .wrap        (sel_wrap)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cur_stage <= '0;
            first_q   <= 1'b0;
            wait_cnt  <= '0;
            instret_q <= '0;
            tfault_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_stage <= cur_stage_nxt;
            first_q   <= first_nxt;
            wait_cnt  <= wait_cnt_nxt;
            instret_q <= instret_nxt;
            tfault_q  <= tfault_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cur_stage_nxt = cur_stage;
        first_nxt     = 1'b0;
        wait_cnt_nxt  = wait_cnt;
        instret_nxt   = instret_q;
        tfault_nxt    = tfault_q;
        case (state)
            IDLE: begin
                state_nxt     = RUN;
                cur_stage_nxt = FETCH_ONEHOT;
                first_nxt     = 1'b1;
                wait_cnt_nxt  = '0;
            end
            RUN: begin
                // Fault beats completion, and completion beats the timeout.
                if (ext_fault) begin
                    state_nxt     = HALT;
                    cur_stage_nxt = '0;
                    wait_cnt_nxt  = '0;
                end else if (stage_done) begin
                    cur_stage_nxt = sel_next;
                    first_nxt     = 1'b1;
                    wait_cnt_nxt  = '0;
                    if (sel_wrap) begin
                        instret_nxt = instret_q + INSTRET_W'(1);
                    end
                end else if (at_limit) begin
                    state_nxt     = HALT;
                    cur_stage_nxt = '0;
                    wait_cnt_nxt  = '0;
                    tfault_nxt    = 1'b1;
                end else if (wait_cnt != WAIT_LIMIT) begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            HALT: begin
                cur_stage_nxt = '0;
                wait_cnt_nxt  = '0;
            end
            default: begin
                state_nxt     = IDLE;
                cur_stage_nxt = '0;
                wait_cnt_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        stage_active  = (state == RUN) ? cur_stage : '0;
        stage_first   = (state == RUN) && first_q;
        retire        = retire_now;
        instret       = instret_q;
        timeout_fault = tfault_q;
        halted        = (state == HALT);
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: a cycle table on a default instance plus
// short sequences for timeout, counter wrap and asynchronous reset on a small one.
module tb_stage_sequencer;

    localparam int NS = 6;

    logic          clk;
    logic          reset;
    logic [NS-1:0] enable_mask;
    logic          stage_done;
    logic          ext_fault;

    logic [NS-1:0] a_active;
    logic          a_first, a_retire, a_tfault, a_halted;
    logic [31:0]   a_instret;

    logic [NS-1:0] s_active;
    logic          s_first, s_retire, s_tfault, s_halted;
    logic [2:0]    s_instret;

    int checks;
    int failures;
    int model_ir;

    typedef struct {
        logic [NS-1:0] mask;
        logic          done;
        logic          fault;
        logic [NS-1:0] exp_active;
        logic          exp_first;
        logic          exp_retire;
        logic          exp_halted;
        int            exp_instret;
    } vec_t;

    vec_t vecs[$];

    stage_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .enable_mask   (enable_mask),
        .stage_done    (stage_done),
        .ext_fault     (ext_fault),
        .stage_active  (a_active),
        .stage_first   (a_first),
        .retire        (a_retire),
        .instret       (a_instret),
        .timeout_fault (a_tfault),
        .halted        (a_halted)
    );

    stage_sequencer #(
        .NUM_STAGES     (NS),
        .TIMEOUT_CYCLES (4),
        .INSTRET_W      (3)
    ) dut_s (
        .clk           (clk),
        .reset         (reset),
        .enable_mask   (enable_mask),
        .stage_done    (stage_done),
        .ext_fault     (ext_fault),
        .stage_active  (s_active),
        .stage_first   (s_first),
        .retire        (s_retire),
        .instret       (s_instret),
        .timeout_fault (s_tfault),
        .halted        (s_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [NS-1:0] mask, input logic done, input logic fault,
                           input logic [NS-1:0] act, input logic first, input logic ret,
                           input logic halt);
        vec_t v;
        v.mask        = mask;
        v.done        = done;
        v.fault       = fault;
        v.exp_active  = act;
        v.exp_first   = first;
        v.exp_retire  = ret;
        v.exp_halted  = halt;
        v.exp_instret = model_ir;
        if (ret) model_ir++;
        vecs.push_back(v);
    endtask

    // Holds reset low, checks the reset values, releases between edges and
    // leaves the bench one edge later with stage 0 freshly active.
    task automatic do_reset();
        reset       = 1'b0;
        enable_mask = '0;
        stage_done  = 1'b0;
        ext_fault   = 1'b0;
        step();
        step();
        check("rst_active", 32'(a_active), 0);
        check("rst_first", 32'(a_first), 0);
        check("rst_retire", 32'(a_retire), 0);
        check("rst_instret", a_instret, 0);
        check("rst_tfault", 32'(a_tfault), 0);
        check("rst_halted", 32'(a_halted), 0);
        check("rst_s_tfault", 32'(s_tfault), 0);
        check("rst_s_halted", 32'(s_halted), 0);
        #3 reset = 1'b1;
        step();
        check("rel_active", 32'(a_active), 32'h01);
        check("rel_first", 32'(a_first), 1);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        model_ir    = 0;
        reset       = 1'b0;
        enable_mask = '0;
        stage_done  = 1'b0;
        ext_fault   = 1'b0;

        // Full mask walk: 18 cycles, retire on every stage-5 exit.
        for (int i = 0; i < 18; i++)
            add_vec(6'h3F, 1'b1, 1'b0, 6'(1 << (i % 6)), 1'b1, (i % 6) == 5, 1'b0);
        // Sparse mask 101011: stages 0,1,3,5.
        add_vec(6'h2B, 1'b1, 1'b0, 6'h01, 1'b1, 1'b0, 1'b0);
        add_vec(6'h2B, 1'b1, 1'b0, 6'h02, 1'b1, 1'b0, 1'b0);
        add_vec(6'h2B, 1'b1, 1'b0, 6'h08, 1'b1, 1'b0, 1'b0);
        add_vec(6'h2B, 1'b1, 1'b0, 6'h20, 1'b1, 1'b1, 1'b0);
        add_vec(6'h2B, 1'b1, 1'b0, 6'h01, 1'b1, 1'b0, 1'b0);
        // Hold in stage 1 while not done.
        add_vec(6'h2B, 1'b0, 1'b0, 6'h02, 1'b1, 1'b0, 1'b0);
        add_vec(6'h2B, 1'b0, 1'b0, 6'h02, 1'b0, 1'b0, 1'b0);
        add_vec(6'h2B, 1'b0, 1'b0, 6'h02, 1'b0, 1'b0, 1'b0);
        // No higher stage enabled: wrap and retire; 0 -> 0 still marks first.
        add_vec(6'h01, 1'b1, 1'b0, 6'h02, 1'b0, 1'b1, 1'b0);
        add_vec(6'h01, 1'b1, 1'b0, 6'h01, 1'b1, 1'b1, 1'b0);
        add_vec(6'h00, 1'b1, 1'b0, 6'h01, 1'b1, 1'b1, 1'b0);
        add_vec(6'h20, 1'b1, 1'b0, 6'h01, 1'b1, 1'b0, 1'b0);
        // Fault together with done in stage 5: halt, no retire.
        add_vec(6'h3F, 1'b1, 1'b1, 6'h20, 1'b1, 1'b0, 1'b0);
        add_vec(6'h3F, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
        add_vec(6'h3F, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b1);

        do_reset();
        foreach (vecs[i]) begin
            enable_mask = vecs[i].mask;
            stage_done  = vecs[i].done;
            ext_fault   = vecs[i].fault;
            #1;
            check($sformatf("v%0d_active", i), 32'(a_active), 32'(vecs[i].exp_active));
            check($sformatf("v%0d_first", i), 32'(a_first), 32'(vecs[i].exp_first));
            check($sformatf("v%0d_retire", i), 32'(a_retire), 32'(vecs[i].exp_retire));
            check($sformatf("v%0d_halted", i), 32'(a_halted), 32'(vecs[i].exp_halted));
            check($sformatf("v%0d_instret", i), a_instret, 32'(vecs[i].exp_instret));
            step();
        end
        check("fault_tfault", 32'(a_tfault), 0);

        // Timeout: 5 cycles waiting in stage 2, then HALT with sticky fault.
        do_reset();
        enable_mask = 6'h3F;
        stage_done  = 1'b1;
        step();
        step();
        stage_done = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("to_wait%0d_active", k), 32'(s_active), 32'h04);
            check($sformatf("to_wait%0d_halted", k), 32'(s_halted), 0);
            step();
        end
        check("to_halted", 32'(s_halted), 1);
        check("to_tfault", 32'(s_tfault), 1);
        check("to_active", 32'(s_active), 0);
        check("to_default_active", 32'(a_active), 32'h04);
        check("to_default_tfault", 32'(a_tfault), 0);
        step();
        check("to_sticky", 32'(s_tfault), 1);

        // Done on the limit cycle wins; the counter restarts in the next stage.
        do_reset();
        enable_mask = 6'h3F;
        stage_done  = 1'b1;
        step();
        step();
        stage_done = 1'b0;
        repeat (4) step();
        stage_done = 1'b1;
        step();
        stage_done = 1'b0;
        check("lim_active", 32'(s_active), 32'h08);
        check("lim_first", 32'(s_first), 1);
        check("lim_tfault", 32'(s_tfault), 0);
        check("lim_halted", 32'(s_halted), 0);
        repeat (4) step();
        check("lim_wait5_active", 32'(s_active), 32'h08);
        step();
        check("lim_halted2", 32'(s_halted), 1);
        check("lim_tfault2", 32'(s_tfault), 1);

        // Nine single-stage instructions: 3-bit counter wraps to 1.
        do_reset();
        enable_mask = 6'h01;
        stage_done  = 1'b1;
        #1;
        check("wrap_retire", 32'(s_retire), 1);
        repeat (9) step();
        stage_done = 1'b0;
        check("wrap_s_instret", 32'(s_instret), 1);
        check("wrap_a_instret", a_instret, 9);

        // Asynchronous reset in the middle of stage 3.
        do_reset();
        enable_mask = 6'h01;
        stage_done  = 1'b1;
        step();
        step();
        enable_mask = 6'h3F;
        step();
        step();
        step();
        check("ar_pre_active", 32'(a_active), 32'h08);
        check("ar_pre_instret", a_instret, 2);
        #3 reset = 1'b0;
        #1;
        check("ar_active", 32'(a_active), 0);
        check("ar_first", 32'(a_first), 0);
        check("ar_retire", 32'(a_retire), 0);
        check("ar_instret", a_instret, 0);
        check("ar_halted", 32'(a_halted), 0);
        #2 reset = 1'b1;
        stage_done = 1'b0;
        #1;
        check("ar_idle_active", 32'(a_active), 0);
        step();
        check("ar_rel_active", 32'(a_active), 32'h01);
        check("ar_rel_first", 32'(a_first), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
